snowball_cpu_responder: RTL and testbench

//  Responder (target) end of the CPU-side cache port: cache_precycle_{addr,we,enable},

---
 rtl/snowball_cpu_pkg.sv | 19 +
 rtl/snowball_scratch_ram.sv | 30 +++
 rtl/snowball_cpu_responder.sv | 152 +++++++++++++++
 tb/tb_snowball_cpu_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/snowball_cpu_pkg.sv
// Shared types for the CPU-side cache port: request record, responder FSM states
// and the wait-state bound.
package snowball_cpu_pkg;

  localparam int WAIT_MAX = 15;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } cpu_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/snowball_scratch_ram.sv
// 1R1W synchronous scratchpad, 2**ADDR_W x 32, registered read data, write-first.
// Kept behind a plain port list so a hard RAM macro can be dropped in.
module snowball_scratch_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  // NOTE: the array and its read register carry no reset; RAM contents are
  // undefined after power-up and a reset port would block RAM inference.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata_q   <= wdata;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/snowball_cpu_responder.sv
// CPU cache-port responder: scratchpad RAM behind an address window, with
// programmable wait states, a one-entry pending slot and a sticky overrun flag.
module snowball_cpu_responder
  import snowball_cpu_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] cache_precycle_addr,
  input  logic        cache_precycle_we,
  input  logic        cache_precycle_enable,
  input  logic [31:0] cache_datao,
  output logic [31:0] cache_datai,
  output logic        cache_busy,
  output logic        MMU_FAULT,
  output logic        overrun
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  cpu_req_t    pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_data_q, req_data_d;
  logic        req_fault_q, req_fault_d;
  logic [31:0] datai_q, datai_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;
  logic        overrun_q, overrun_d;

  cpu_req_t          in_req, acc_req;
  logic              accept, acc_fault;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata, resp_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^acc_req.addr[1:0];
  assign resp_data = req_we_q    ? req_data_q :
                     req_fault_q ? 32'h0      : ram_rdata;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    in_req     = '{addr: cache_precycle_addr, we: cache_precycle_we, data: cache_datao};
    acc_req    = pend_vld_q ? pend_q : in_req;
    acc_fault  = acc_req.addr[31:ADDR_W+2] != BASE[31:ADDR_W+2];
    accept     = ((state_q == ST_IDLE) || (state_q == ST_RESP)) &&
                 (pend_vld_q || cache_precycle_enable);
    ram_addr   = acc_req.addr[ADDR_W+1:2];
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    req_we_d    = req_we_q;
    req_data_d  = req_data_q;
    req_fault_d = req_fault_q;
    datai_d     = datai_q;
    busy_d      = (state_q == ST_WAIT);
    fault_d     = 1'b0;
    overrun_d   = overrun_q;

    if (state_q == ST_RESP) begin
      datai_d = resp_data;
      fault_d = req_fault_q;
      state_d = ST_IDLE;
    end

    if (state_q == ST_WAIT) begin
      if (cnt_q == 4'd1) state_d = ST_RESP;
      if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    end

    if (accept) begin
      req_we_d    = acc_req.we;
      req_data_d  = acc_req.data;
      req_fault_d = acc_fault;
      ram_we      = acc_req.we && !acc_fault && !RST;
      ram_re      = !acc_req.we && !RST;
      cnt_d       = WAIT_INIT;
      state_d     = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
    end

    // A pending request always goes first; a same-cycle new enable refills the slot.
    if (cache_precycle_enable) begin
      if (accept && pend_vld_q) begin
        pend_d = in_req;
      end else if (!accept) begin
        if (!pend_vld_q) begin
          pend_d     = in_req;
          pend_vld_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end else if (accept && pend_vld_q) begin
      pend_vld_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      pend_vld_q <= 1'b0;
      datai_q    <= 32'h0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      datai_q    <= datai_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge CLK) begin
    pend_q      <= pend_d;
    req_we_q    <= req_we_d;
    req_data_q  <= req_data_d;
    req_fault_q <= req_fault_d;
  end

  snowball_scratch_ram #(.ADDR_W(ADDR_W)) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (acc_req.data),
    .rdata (ram_rdata)
  );

  assign cache_datai = datai_q;
  assign cache_busy  = busy_q;
  assign MMU_FAULT   = fault_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_snowball_cpu_responder.sv
// Directed bench: four responders (W = 0, 3, 2, 4) on a shared clock, each
// driven at negedge and observed at the following negedge.
module tb_snowball_cpu_responder;

  localparam int WS [4] = '{0, 3, 2, 4};

  logic        CLK;
  logic        rst   [4];
  logic        en    [4];
  logic        we    [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  logic        busy  [4];
  logic        fault [4];
  logic        ovr   [4];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    snowball_cpu_responder #(
      .ADDR_W      (8),
      .BASE        (32'h0000_0000),
      .WAIT_CYCLES (WS[g])
    ) u_dut (
      .CLK                   (CLK),
      .RST                   (rst[g]),
      .cache_precycle_addr   (addr[g]),
      .cache_precycle_we     (we[g]),
      .cache_precycle_enable (en[g]),
      .cache_datao           (wdata[g]),
      .cache_datai           (rdata[g]),
      .cache_busy            (busy[g]),
      .MMU_FAULT             (fault[g]),
      .overrun               (ovr[g])
    );
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic drive(input int i, input logic e, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    en[i] = e; we[i] = w; addr[i] = a; wdata[i] = d;
  endtask

  // One request, then idle until its response is on the outputs.
  task automatic single(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    drive(i, 1'b1, w, a, d);
    cyc();
    drive(i, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (WS[i] + 1) cyc();
  endtask

  logic [31:0] vals [3];

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      drive(i, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    repeat (3) cyc();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_datai%0d", i), rdata[i], 32'h0);
      check($sformatf("rst_busy%0d", i),  busy[i],  1'b0);
      check($sformatf("rst_fault%0d", i), fault[i], 1'b0);
      check($sformatf("rst_ovr%0d", i),   ovr[i],   1'b0);
      rst[i] = 1'b0;
    end
    cyc();

    // W=0 write then read word 0
    drive(0, 1'b1, 1'b1, 32'h0, 32'h5454_6969); cyc();
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);         cyc();
    check("t1_echo", rdata[0], 32'h5454_6969);
    check("t1_busy_a", busy[0], 1'b0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);         cyc();
    check("t1_read", rdata[0], 32'h5454_6969);
    check("t1_busy_b", busy[0], 1'b0);

    // W=0 out-of-window write, read, then in-window read of the aliased word
    drive(0, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF); cyc();
    drive(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0);         cyc();
    check("t3_wr_fault", fault[0], 1'b1);
    drive(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);         cyc();
    check("t3_rd_data", rdata[0], 32'h0);
    check("t3_rd_fault", fault[0], 1'b1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);                 cyc();
    check("t3_alias_data", rdata[0], 32'h5454_6969);
    check("t3_alias_fault", fault[0], 1'b0);
    cyc();
    check("t3_hold", rdata[0], 32'h5454_6969);
    check("t3_fault_low", fault[0], 1'b0);

    // W=0 back-to-back alternating write/read on word 5
    vals[0] = 32'h1111_0005; vals[1] = 32'h2222_0005; vals[2] = 32'h3333_0005;
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'b1, (k % 2) == 0, 32'h14, vals[k / 2]);
      cyc();
      if (k > 0) check($sformatf("t6_resp%0d", k - 1), rdata[0], vals[(k - 1) / 2]);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0); cyc();
    check("t6_resp5", rdata[0], vals[2]);

    // Reset and enable on the same edge: the write is discarded
    rst[0] = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h0, 32'hFFFF_0000); cyc();
    rst[0] = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);         cyc();
    check("rst_en_datai", rdata[0], 32'h0);
    single(0, 1'b0, 32'h0, 32'h0);
    check("rst_en_mem", rdata[0], 32'h5454_6969);

    // W=3 read with wait states
    single(1, 1'b1, 32'h10, 32'h5a5a_dadd);
    check("t2_pre_echo", rdata[1], 32'h5a5a_dadd);
    single(1, 1'b1, 32'h20, 32'h1111_2222);
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0); cyc();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check($sformatf("t2_busy_e%0d", k), busy[1], 1'b1);
    end
    cyc();
    check("t2_busy_e4", busy[1], 1'b0);
    check("t2_data", rdata[1], 32'h5a5a_dadd);

    // W=2 three enables in a row: second queued, third dropped
    single(2, 1'b1, 32'hC, 32'h0C0C_0C0C);
    drive(2, 1'b1, 1'b1, 32'h4, 32'hAAAA_0001); cyc();
    check("t4_ovr_e0", ovr[2], 1'b0);
    drive(2, 1'b1, 1'b1, 32'h8, 32'hBBBB_0002); cyc();
    check("t4_busy_e1", busy[2], 1'b1);
    drive(2, 1'b1, 1'b1, 32'hC, 32'hCCCC_0003); cyc();
    check("t4_busy_e2", busy[2], 1'b1);
    check("t4_ovr_e2", ovr[2], 1'b1);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);         cyc();
    check("t4_resp_a", rdata[2], 32'hAAAA_0001);
    check("t4_busy_e3", busy[2], 1'b0);
    cyc();
    check("t4_busy_e4", busy[2], 1'b1);
    cyc();
    check("t4_busy_e5", busy[2], 1'b1);
    cyc();
    check("t4_resp_b", rdata[2], 32'hBBBB_0002);
    check("t4_busy_e6", busy[2], 1'b0);
    cyc();
    check("t4_idle_busy", busy[2], 1'b0);
    single(2, 1'b0, 32'hC, 32'h0);
    check("t4_dropped", rdata[2], 32'h0C0C_0C0C);
    single(2, 1'b0, 32'h8, 32'h0);
    check("t4_b_mem", rdata[2], 32'hBBBB_0002);
    check("t4_ovr_sticky", ovr[2], 1'b1);
    rst[2] = 1'b1; cyc(); rst[2] = 1'b0;
    check("t4_ovr_clr", ovr[2], 1'b0);

    // W=4 reset mid-wait, for a write and then for a read
    drive(3, 1'b1, 1'b1, 32'h40, 32'h7777_1234); cyc();
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0);         cyc();
    check("t5_busy_w", busy[3], 1'b1);
    rst[3] = 1'b1; cyc(); rst[3] = 1'b0;
    check("t5_rst_busy_w", busy[3], 1'b0);
    check("t5_rst_data_w", rdata[3], 32'h0);
    drive(3, 1'b1, 1'b0, 32'h40, 32'h0); cyc();
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0);  cyc();
    rst[3] = 1'b1; cyc(); rst[3] = 1'b0;
    check("t5_rst_busy_r", busy[3], 1'b0);
    repeat (5) cyc();
    check("t5_lost_read", rdata[3], 32'h0);
    check("t5_lost_busy", busy[3], 1'b0);
    single(3, 1'b0, 32'h40, 32'h0);
    check("t5_write_kept", rdata[3], 32'h7777_1234);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
